cpl_timeout_tracker: RTL



---
 rtl/cpl_timeout_tracker_pkg.sv | 33 +++
 rtl/cpl_timeout_tracker_tag_timer.sv | 70 +++++++
 rtl/cpl_timeout_tracker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpl_timeout_tracker_pkg.sv
// cto_pkg: shared types and constants for the completion-timeout tracker.
//   tag_state_t  per-tag lifecycle (IDLE / ACTIVE / EXPIRED)
//   DC2_*        DevCtl2 field positions
//   CTO_THR      timeout threshold in ticks for each 4-bit value code
//   cto_ticks()  value code -> threshold lookup
package cto_pkg;

    typedef enum logic [1:0] {
        TAG_IDLE    = 2'd0,
        TAG_ACTIVE  = 2'd1,
        TAG_EXPIRED = 2'd2
    } tag_state_t;

    localparam int unsigned DC2_W       = 16;
    localparam int unsigned DC2_VAL_LSB = 0;
    localparam int unsigned DC2_VAL_MSB = 3;
    localparam int unsigned DC2_DIS_BIT = 4;

    localparam int unsigned CTO_TICKS_W = 26;

    // Reserved codes fall back to the 50,000-tick default.
    localparam logic [CTO_TICKS_W-1:0] CTO_THR [16] = '{
        26'd50_000,     26'd100,        26'd10_000,     26'd50_000,
        26'd50_000,     26'd55_000,     26'd210_000,    26'd50_000,
        26'd50_000,     26'd900_000,    26'd3_500_000,  26'd50_000,
        26'd50_000,     26'd13_000_000, 26'd64_000_000, 26'd50_000
    };

    function automatic logic [CTO_TICKS_W-1:0] cto_ticks(input logic [3:0] value);
        return CTO_THR[value];
    endfunction

endpackage

// File: rtl/cpl_timeout_tracker_tag_timer.sv
// cto_tag_timer: state and tick counter for one request tag.
//   clk, reset   clock, async active-high reset
//   tick         prescaler pulse
//   dis          timeout disable (counter holds, no expiry)
//   thr          current threshold in ticks
//   start        request accepted for this (IDLE) tag
//   cpl_final    final completion for this (non-IDLE) tag
//   rpt_ack      this tag's timeout report was accepted
//   state        current tag state
module cto_tag_timer
    import cto_pkg::*;
#(
    parameter int unsigned TIMER_W = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               dis,
    input  logic [TIMER_W-1:0] thr,
    input  logic               start,
    input  logic               cpl_final,
    input  logic               rpt_ack,
    output tag_state_t         state
);

    tag_state_t         state_n;
    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cnt_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TAG_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            TAG_IDLE: begin
                if (start) begin
                    state_n = TAG_ACTIVE;
                    cnt_n   = '0;
                end
            end
            TAG_ACTIVE: begin
                if (cpl_final) begin
                    state_n = TAG_IDLE;
                end else if (!dis) begin
                    if (cnt >= thr) begin
                        state_n = TAG_EXPIRED;
                    end else if (tick && (cnt != '1)) begin
                        cnt_n = cnt + TIMER_W'(1);
                    end
                end
            end
            TAG_EXPIRED: begin
                if (cpl_final || rpt_ack) begin
                    state_n = TAG_IDLE;
                end
            end
            default: state_n = TAG_IDLE;
        endcase
    end

endmodule

// File: rtl/cpl_timeout_tracker.sv
// cpl_timeout_tracker: DevCtl2 completion-timeout fields plus one timer per
// outstanding non-posted tag; expired tags are reported round-robin over a
// valid/ready handshake.
//   cfg_wr_en/cfg_wr_data  DevCtl2 write; devctl2 readback ([4:0] live)
//   req_valid/req_tag      request issue; req_err pulses on a bad request
//   cpl_valid/cpl_tag/cpl_last  completion; cpl_unexp pulses on a stray one
//   to_valid/to_tag/to_ready    timeout report handshake
//   outstanding_cnt        registered count of non-IDLE tags
module cpl_timeout_tracker
    import cto_pkg::*;
#(
    parameter int unsigned NUM_TAGS = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned TIMER_W  = 26,
    parameter int unsigned TICK_DIV = 125
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr_en,
    input  logic [15:0]        cfg_wr_data,
    output logic [15:0]        devctl2,
    input  logic               req_valid,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               req_err,
    input  logic               cpl_valid,
    input  logic [TAG_W-1:0]   cpl_tag,
    input  logic               cpl_last,
    output logic               cpl_unexp,
    output logic               to_valid,
    output logic [TAG_W-1:0]   to_tag,
    input  logic               to_ready,
    output logic [TAG_W:0]     outstanding_cnt
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = TAG_W + 1;

    logic [DC2_DIS_BIT:0] cfg;
    logic                 cfg_unused;
    logic [PW-1:0]        presc;
    logic                 tick;
    logic [TIMER_W-1:0]   thr;
    logic                 dis;

    logic [NUM_TAGS-1:0]  req_hit, cpl_hit, idle_vec, exp_vec;
    logic [NUM_TAGS-1:0]  final_vec, ack_vec, cand;
    logic                 accept, present_gone;
    logic [TAG_W-1:0]     rr_last, rr_base;
    logic                 hi_found, lo_found;
    logic [TAG_W-1:0]     hi_pick, lo_pick;
    logic [CW-1:0]        busy_n;

    assign devctl2    = {{(DC2_W-DC2_DIS_BIT-1){1'b0}}, cfg};
    assign cfg_unused = ^cfg_wr_data[DC2_W-1:DC2_DIS_BIT+1];
    assign thr        = TIMER_W'(cto_ticks(cfg[DC2_VAL_MSB:DC2_VAL_LSB]));
    assign dis        = cfg[DC2_DIS_BIT];
    assign tick       = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg   <= '0;
            presc <= '0;
        end else begin
            if (cfg_wr_en) cfg <= cfg_wr_data[DC2_DIS_BIT:0];
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    assign accept       = to_valid && to_ready;
    assign present_gone = cpl_valid && cpl_last && (cpl_tag == to_tag);

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
        tag_state_t st;

        assign req_hit[g]   = req_valid && (req_tag == TAG_W'(g));
        assign cpl_hit[g]   = cpl_valid && (cpl_tag == TAG_W'(g));
        assign idle_vec[g]  = (st == TAG_IDLE);
        assign exp_vec[g]   = (st == TAG_EXPIRED);
        assign final_vec[g] = cpl_hit[g] && cpl_last && !idle_vec[g];
        assign ack_vec[g]   = accept && (to_tag == TAG_W'(g));
        // Tags leaving EXPIRED this cycle must not be offered next cycle.
        assign cand[g]      = exp_vec[g] && !final_vec[g] && !ack_vec[g];

        cto_tag_timer #(.TIMER_W(TIMER_W)) u_timer (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .dis       (dis),
            .thr       (thr),
            .start     (req_hit[g] && idle_vec[g]),
            .cpl_final (final_vec[g]),
            .rpt_ack   (ack_vec[g]),
            .state     (st)
        );
    end

    // Round-robin: first candidate above the base wins, else the lowest
    // candidate at or below it (wrap-around).
    assign rr_base = accept ? to_tag : rr_last;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int unsigned j = 0; j < NUM_TAGS; j++) begin
            if (cand[j]) begin
                if (TAG_W'(j) > rr_base) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_pick  = TAG_W'(j);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_pick  = TAG_W'(j);
                end
            end
        end
    end

    always_comb begin
        busy_n = '0;
        for (int unsigned j = 0; j < NUM_TAGS; j++) begin
            if (!idle_vec[j]) busy_n = busy_n + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_valid        <= 1'b0;
            to_tag          <= '0;
            rr_last         <= TAG_W'(NUM_TAGS - 1);
            req_err         <= 1'b0;
            cpl_unexp       <= 1'b0;
            outstanding_cnt <= '0;
        end else begin
            // Presented report is held unless accepted or withdrawn by completion.
            if (!to_valid || accept || present_gone) begin
                to_valid <= hi_found || lo_found;
                if (hi_found)      to_tag <= hi_pick;
                else if (lo_found) to_tag <= lo_pick;
            end
            if (accept) rr_last <= to_tag;
            req_err   <= req_valid && !(|(req_hit & idle_vec));
            cpl_unexp <= cpl_valid && (!(|(cpl_hit & ~idle_vec)) ||
                                       (accept && (cpl_tag == to_tag)));
            outstanding_cnt <= busy_n;
        end
    end

endmodule
